kgp_fetch_unit: RTL and testbench
=================================

// Module: kgp_fetch_unit
// PURPOSE
//  Instruction fetch stage for the KGPRISC core; sits between the synchronous
//  instruction memory and the decode stage. Owns the PC, issues one sequential
//  read per cycle, and presents {instr, pc} to decode through a stall/redirect
//  interface. A 1-entry skid buffer absorbs the memory's 1-cycle read latency.
//  Detects HALT and freezes the front end until reset.
// PARAMETERS
//  ADDR_W    10      instruction memory word-address width
//  INSTR_W   32      instruction width
//  RESET_PC  0       first fetch address after reset
//  HALT_OP   6'h3F   opcode (instr[INSTR_W-1 -: 6]) that halts fetch
// PORTS
//  clk             in   1        core clock, all state on rising edge
//  reset           in   1        asynchronous, active-low reset
//  imem_addr       out  ADDR_W   read word address (= pc_q)
//  imem_rd_en      out  1        read strobe; data returns on imem_rdata next cycle
//  imem_rdata      in   INSTR_W  read data, valid the cycle after imem_rd_en=1
//  stall           in   1        decode cannot accept; hold outputs
//  redirect_valid  in   1        1-cycle pulse: branch/jump taken
//  redirect_pc     in   ADDR_W   target address, sampled when redirect_valid=1
//  instr_out       out  INSTR_W  instruction to decode
//  pc_out          out  ADDR_W   address of instr_out
//  pc_plus1_out    out  ADDR_W   pc_out+1, mod 2^ADDR_W
//  instr_valid     out  1        instr_out/pc_out are valid
//  halted          out  1        HALT was accepted by decode; fetch frozen
// BEHAVIOUR
//  Reset (reset=0, async): state=BOOT, pc_q=RESET_PC, instr_out=0,
//   pc_out=RESET_PC, pc_plus1_out=RESET_PC+1, instr_valid=0, imem_rd_en=0,
//   halted=0, skid empty, no read in flight.
//  States: BOOT -> RUN on first clk edge after reset release; RUN -> HALTED
//   when a HALT_OP instr is accepted; HALTED exits only via reset.
//  Accept: decode consumes the output when instr_valid=1 && stall=0.
//  Issue: imem_rd_en = (state==RUN) && !stall && skid empty && !halt_seen;
//   on issue pc_q <= pc_q+1 (wraps 2^ADDR_W-1 -> 0), in-flight tag = pc_q.
//  Return (cycle after issue): load output regs if output empty or accepted
//   this cycle; otherwise load skid. Skid drains into output before any new
//   return word; order is strictly program order.
//  Stall: outputs held bit-stable; at most one in-flight word lands in skid;
//   no further issue until skid empties. Stall release -> skid word presented
//   next cycle, issue resumes the same cycle skid drains.
//  Redirect: priority over stall and return. Same edge: instr_valid<=0, skid
//   cleared, in-flight word discarded (its rdata next cycle ignored),
//   pc_q<=redirect_pc, halt_seen cleared. Target issued next cycle, target
//   instr_valid=1 two cycles after redirect pulse. Ignored in BOOT/HALTED.
//  Redirect and accept in same cycle: accept counts, then flush.
//  Halt: when HALT_OP word enters output, halt_seen=1 blocks issue, words after
//   it (in flight/skid) discarded; on its accept -> HALTED, halted=1,
//   instr_valid=0, imem_rd_en=0. Redirect before accept cancels the halt.
//  Reset mid-operation: immediate return to reset values, in-flight data lost.
// TESTING
//  1 Reset release, mem[i]=i, stall=0 -> imem_rd_en=1 cycle 1; instr_valid=1
//    from cycle 2 with pc_out=0,1,2... one per cycle, pc_plus1_out=pc_out+1.
//  2 Stall 3 cycles while pc_out=5 -> outputs frozen at 5; release -> 6,7,8
//    back-to-back, no duplicate or skipped pc.
//  3 redirect_valid with redirect_pc=0x40 while pc_out=10 -> next cycle
//    instr_valid=0, following cycle pc_out=0x40; word for pc 11 never shown.
//  4 Redirect while stall=1 and skid full -> skid dropped, pc_out=target after 2.
//  5 mem[3]=HALT_OP word -> pc 3 presented, accepted, halted=1, imem_rd_en=0
//    forever; redirect ignored; reset pulse restarts at RESET_PC.
//  6 ADDR_W=4, run past 15 -> pc_out wraps 15->0; async reset mid-stall ->
//    all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/kgp_fetch_unit.sv
// ---------------------------------------------------------------------------
// kgp_fetch_unit
//
// Instruction fetch stage for the KGPRISC core. Owns the PC, issues one
// sequential read per cycle to a synchronous instruction memory (1-cycle read
// latency) and hands {instr, pc} to decode through a stall/redirect handshake.
// A HALT opcode freezes the front end until reset.
//
// Ports
//   clk            in   core clock, all state on the rising edge
//   reset          in   asynchronous, active-low reset
//   imem_addr      out  read word address (the PC)
//   imem_rd_en     out  read strobe; data appears on imem_rdata next cycle
//   imem_rdata     in   read data, valid the cycle after imem_rd_en
//   stall          in   decode cannot accept; presented word is held
//   redirect_valid in   1-cycle pulse: branch/jump taken
//   redirect_pc    in   redirect target, sampled with redirect_valid
//   instr_out      out  instruction to decode
//   pc_out         out  address of instr_out
//   pc_plus1_out   out  pc_out + 1, wrapping at 2^ADDR_W
//   instr_valid    out  instr_out/pc_out are valid
//   halted         out  a HALT word was accepted; fetch is frozen
//
// Presentation scheme
//   A returning word is shown to decode straight from imem_rdata in its
//   return cycle, so a word issued in cycle N is visible in cycle N+1. If
//   decode does not take it, the 1-entry skid captures it at the clock edge
//   and presents it bit-stable from then on. Issue is gated by !stall, so
//   whenever a read is issued the currently presented word (skid or fresh)
//   is being accepted that same cycle: the skid drains in the very cycle
//   issue resumes and a returning word never collides with a full skid.
// ---------------------------------------------------------------------------
module kgp_fetch_unit #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned RESET_PC = 0,
  parameter logic [5:0]  HALT_OP  = 6'h3F
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus1_out,
  output logic               instr_valid,
  output logic               halted
);

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalted
  } state_e;

  state_e state_q, state_d;

  // Fetch PC and the tag of the read issued last cycle.
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  tag_q, tag_d;

  // Skid: holds a presented word that decode has not taken yet.
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;

  // Word currently presented to decode.
  logic               cur_valid;
  logic [INSTR_W-1:0] cur_instr;
  logic [ADDR_W-1:0]  cur_pc;
  logic               cur_is_halt;

  logic               accept;
  logic               halt_accept;
  logic               do_redirect;
  logic               issue;

  // -------------------------------------------------------------------------
  // Presented word and handshake decode
  // -------------------------------------------------------------------------
  always_comb begin
    // inflight and skid are never valid together (see header).
    cur_valid   = inflight_q | skid_valid_q;
    cur_instr   = inflight_q ? imem_rdata : skid_instr_q;
    cur_pc      = inflight_q ? tag_q : skid_pc_q;
    // halt_seen: a HALT word sits at the output; blocks further issue.
    cur_is_halt = cur_valid && (cur_instr[INSTR_W-1 -: 6] == HALT_OP);
    accept      = cur_valid && !stall;
    halt_accept = accept && cur_is_halt;
    // An accepted HALT wins over a same-cycle redirect.
    do_redirect = (state_q == StRun) && redirect_valid && !halt_accept;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot:   state_d = StRun;
      StRun:    if (halt_accept) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StBoot;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    imem_rd_en   = (state_q == StRun) && !stall && !cur_is_halt;
    imem_addr    = pc_q;
    halted       = (state_q == StHalted);
    instr_valid  = cur_valid;
    instr_out    = cur_instr;
    pc_out       = cur_pc;
    pc_plus1_out = cur_pc + ADDR_W'(1);
  end

  // -------------------------------------------------------------------------
  // Datapath next state
  // -------------------------------------------------------------------------
  always_comb begin
    issue        = imem_rd_en;
    pc_d         = pc_q;
    inflight_d   = 1'b0;
    tag_d        = tag_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (issue) begin
      pc_d       = pc_q + ADDR_W'(1);
      inflight_d = 1'b1;
      tag_d      = pc_q;
    end

    // Capture the fresh word every return so outputs stay stable afterwards.
    if (inflight_q) begin
      skid_instr_d = imem_rdata;
      skid_pc_d    = tag_q;
    end
    skid_valid_d = cur_valid && !accept;

    // Flush: drop skid and the read issued this cycle, retarget the PC.
    if (do_redirect) begin
      pc_d         = redirect_pc;
      inflight_d   = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= ResetPc;
      inflight_q   <= 1'b0;
      tag_q        <= ResetPc;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= ResetPc;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      tag_q        <= tag_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_kgp_fetch_unit.sv
module tb_kgp_fetch_unit;

  localparam int AW    = 7;
  localparam int IW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_addr;
  logic          imem_rd_en;
  logic [IW-1:0] imem_rdata;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] pc_plus1_out;
  logic          instr_valid;
  logic          halted;

  kgp_fetch_unit #(
    .ADDR_W  (AW),
    .INSTR_W (IW),
    .RESET_PC(0),
    .HALT_OP (6'h3F)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rd_en    (imem_rd_en),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .pc_plus1_out  (pc_plus1_out),
    .instr_valid   (instr_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, 1-cycle read latency.
  logic [IW-1:0] mem [DEPTH];
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  int passed = 0;
  int total  = 0;

  // Reference model: the front end is a program-order stream. m_q holds the
  // pcs decode can currently see (issued words arrive one cycle later).
  int m_state;  // 0 boot, 1 run, 2 halted
  int m_pc;
  int m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [IW-1:0] rand_word();
    logic [IW-1:0] w;
    w = $urandom();
    if (w[IW-1 -: 6] == 6'h3F) w[IW-1] = 1'b0;
    return w;
  endfunction

  function automatic int m_cur_pc();
    return (m_state == 1 && m_q.size() > 0) ? m_q[0] : -1;
  endfunction

  function automatic logic is_halt(input int a);
    logic [IW-1:0] w;
    w = mem[a];
    return w[IW-1 -: 6] == 6'h3F;
  endfunction

  // Compare this cycle's outputs with the model, then advance the model
  // across the coming clock edge. Inputs must already be driven.
  task automatic compare_and_advance(input logic st, input logic rv, input int rpc);
    logic cv, ch, er;
    int   cp;
    cv = (m_cur_pc() >= 0);
    cp = cv ? m_q[0] : 0;
    ch = cv && is_halt(cp);
    er = (m_state == 1) && !st && !ch;
    chk("instr_valid", instr_valid, cv);
    chk("imem_rd_en", imem_rd_en, er);
    chk("imem_addr", imem_addr, m_pc);
    chk("halted", halted, m_state == 2);
    if (cv) begin
      chk("pc_out", pc_out, cp);
      chk("pc_plus1_out", pc_plus1_out, (cp + 1) % DEPTH);
      chk("instr_out", instr_out, mem[cp]);
    end
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (cv && !st) begin
        void'(m_q.pop_front());
        if (ch) begin
          m_state = 2;
          m_q.delete();
        end
      end
      if (m_state == 1) begin
        if (er) begin
          m_q.push_back(m_pc);
          m_pc = (m_pc + 1) % DEPTH;
        end
        if (rv) begin
          m_q.delete();
          m_pc = rpc % DEPTH;
        end
      end
    end
  endtask

  task automatic step(input logic st, input logic rv, input int rpc);
    @(negedge clk);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = AW'(rpc);
    #1;
    compare_and_advance(st, rv, rpc);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".instr_valid"}, instr_valid, 0);
    chk({tag, ".imem_rd_en"}, imem_rd_en, 0);
    chk({tag, ".halted"}, halted, 0);
    chk({tag, ".pc_out"}, pc_out, 0);
    chk({tag, ".pc_plus1_out"}, pc_plus1_out, 1);
    chk({tag, ".instr_out"}, instr_out, 0);
  endtask

  // Release at a falling edge and check the BOOT cycle.
  task automatic release_reset();
    m_state = 0;
    m_pc    = 0;
    m_q.delete();
    @(negedge clk);
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    compare_and_advance(1'b0, 1'b0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    reset_checks("reset");
    release_reset();
  endtask

  task automatic run_until(input int target);
    for (int n = 0; n < 300 && m_cur_pc() != target; n++) step(1'b0, 1'b0, 0);
  endtask

  initial begin
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = IW'(i);

    // Sequential stream from reset.
    apply_reset();
    run_until(5);

    // Stall three cycles on pc 5, then resume back-to-back.
    repeat (3) step(1'b1, 1'b0, 0);
    repeat (6) step(1'b0, 1'b0, 0);

    // Redirect while pc 10 is shown.
    run_until(10);
    step(1'b0, 1'b1, 'h40);
    repeat (4) step(1'b0, 1'b0, 0);

    // Redirect while stalled with a word held in the skid.
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 'h20);
    repeat (4) step(1'b0, 1'b0, 0);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 'h7C);
    repeat (8) step(1'b0, 1'b0, 0);

    // Randomized stall/redirect traffic over random program contents.
    for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6,
           int'($urandom_range(0, DEPTH - 1)));
    end

    // HALT presented, then cancelled by a redirect before it is accepted.
    mem['h50] = {6'h3F, 26'($urandom())};
    step(1'b0, 1'b1, 'h4E);
    run_until('h50);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 'h10);
    repeat (5) step(1'b0, 1'b0, 0);
    chk("halt_cancelled", halted, 0);
    mem['h50] = rand_word();

    // HALT at pc 3: accepted, frozen, redirects ignored, reset restarts.
    mem[3] = {6'h3F, 26'($urandom())};
    apply_reset();
    repeat (6) step($urandom_range(0, 99) < 30, 1'b0, 0);
    run_until(3);
    repeat (3) step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 'h20);
    repeat (3) step(1'b0, 1'b0, 0);
    chk("halt_frozen", halted, 1);
    apply_reset();
    repeat (3) step(1'b0, 1'b0, 0);
    mem[3] = rand_word();

    // Asynchronous reset in the middle of a stall, no clock edge needed.
    apply_reset();
    repeat (5) step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    #1;
    reset = 1'b0;
    #1;
    reset_checks("async_reset");
    release_reset();
    repeat (4) step(1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
